// File: rtl/sum_serial_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and the
// default operand width used when the top is instantiated without overrides.
package sum_serial_pkg;

  // FSM state encoding, kept as plain constants so older netlists and
  // waveform viewers that expect raw 2-bit codes keep working.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Default operand/sum width.
  localparam int SUM_WIDTH_DEF = 8;

endpackage

// File: rtl/sum_bit.sv
// One-bit full adder cell. The serial adder pushes every operand bit through
// this single cell, so it is kept purely combinational.
module sum_bit (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  // Sum is the parity of the three inputs, carry is their majority.
  always_comb begin
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/sum_serial.sv
// Bit-serial WIDTH-bit adder. Operands are loaded on an accepted start and
// fed LSB first through a single full-adder cell, one bit per clock, with the
// carry held in a flop between bits. The result appears WIDTH+1 edges after
// start and is held until the next completion.
//
// Optional feature: define SUM_SERIAL_OVF_EN to add the ovf output, which
// flags two's-complement overflow of the completed addition.
module sum_serial
  import sum_serial_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SUM_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // WIDTH is at least 2, so the bit counter is always at least one bit wide.
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  // Holds the WIDTH-1 sum bits produced so far, newest at the top; the bit
  // produced in the current cycle completes the word in sum_next.
  logic [WIDTH-2:0] sh_s;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             cell_s;
  logic             cell_c;
  logic             accept;
  logic             last_bit;

  // The single adder cell, always looking at the current LSBs and the carry.
  sum_bit u_cell (
    .x (sh_a[0]),
    .y (sh_b[0]),
    .z (carry),
    .s (cell_s),
    .c (cell_c)
  );

  // A request is taken in IDLE or in the DONE cycle (back-to-back); while
  // running, start is ignored.
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = (state == S_RUN) && (cnt == CNT_LAST);
  assign sum_next = {cell_s, sh_s};

  // Status outputs are decoded straight from the state register.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand shifters, sum collector, carry flop and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sh_a  <= a;
      sh_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
      sh_s  <= sum_next[WIDTH-1:1];
      carry <= cell_c;
      cnt   <= cnt + 1'b1;
    end
  end

  // Result registers change only when the last bit is processed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= sum_next;
      cout <= cell_c;
    end
  end

`ifdef SUM_SERIAL_OVF_EN
  // While the MSB is processed the carry flop holds the carry into the MSB;
  // overflow is that carry differing from the carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= carry ^ cell_c;
    end
  end
`endif

endmodule

// File: tb/tb_sum_serial.sv
// Self-checking bench for sum_serial: directed cases from the test plan plus
// randomized operands, all checked against plain integer arithmetic.
module tb_sum_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SUM_SERIAL_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] expSum;
  logic         expCout;
  logic         expOvf;
  logic [W-1:0] heldSum  = '0;
  logic         heldCout = 1'b0;
  logic         heldOvf  = 1'b0;

  sum_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SUM_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge and compute the expected result.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int u;
    int s;
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    u = int'(av) + int'(bv) + int'(cv);
    s = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    expSum  = u[W-1:0];
    expCout = u[W];
    expOvf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endtask

  // Follow the operation to its done cycle; optionally re-pulse start mid-run.
  task automatic checkOutput(input string tag, input int midStart);
    int busyCnt = 0;
    int doneAt  = 0;
    for (int n = 1; n <= W + 4 && doneAt == 0; n++) begin
      @(negedge clk);
      if (n == 1 || n == midStart + 1) start = 1'b0;
      if (n == midStart) begin
        start = 1'b1;
        a     = 8'hAA;
      end
      if (busy) begin
        busyCnt++;
        compare({tag, "_held_sum"}, 32'(sum), 32'(heldSum));
      end
      if (done) doneAt = n;
    end
    compare({tag, "_done_cycle"}, 32'(doneAt), 32'(W + 1));
    compare({tag, "_busy_cycles"}, 32'(busyCnt), 32'(W));
    compare({tag, "_sum"}, 32'(sum), 32'(expSum));
    compare({tag, "_cout"}, 32'(cout), 32'(expCout));
`ifdef SUM_SERIAL_OVF_EN
    compare({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
`endif
    heldSum  = expSum;
    heldCout = expCout;
    heldOvf  = expOvf;
  endtask

  // Watch a number of cycles in which nothing should be running.
  task automatic checkQuiet(input string tag, input int cycles);
    int doneSeen = 0;
    int busySeen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done) doneSeen++;
      if (busy) busySeen++;
    end
    compare({tag, "_no_done"}, 32'(doneSeen), 32'd0);
    compare({tag, "_no_busy"}, 32'(busySeen), 32'd0);
    compare({tag, "_sum_kept"}, 32'(sum), 32'(heldSum));
    compare({tag, "_cout_kept"}, 32'(cout), 32'(heldCout));
  endtask

  initial begin
    bit b2b;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    compare("reset_busy", 32'(busy), 32'd0);
    compare("reset_done", 32'(done), 32'd0);
    compare("reset_sum", 32'(sum), 32'd0);
    compare("reset_cout", 32'(cout), 32'd0);
`ifdef SUM_SERIAL_OVF_EN
    compare("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic add");
    applyStimulus(8'h0F, 8'h01, 1'b0);
    checkOutput("basic", 0);
    compare("basic_sum_const", 32'(sum), 32'h10);
    checkQuiet("basic_after", 2);

    $display("[TB] carry chain with carry-in");
    applyStimulus(8'hFF, 8'h00, 1'b1);
    checkOutput("chain", 0);
    compare("chain_sum_const", 32'(sum), 32'h00);
    compare("chain_cout_const", 32'(cout), 32'd1);
    checkQuiet("chain_after", 2);

    $display("[TB] signed overflow");
    applyStimulus(8'h7F, 8'h01, 1'b0);
    checkOutput("ovf", 0);
    compare("ovf_sum_const", 32'(sum), 32'h80);
`ifdef SUM_SERIAL_OVF_EN
    compare("ovf_flag_const", 32'(ovf), 32'd1);
`endif
    checkQuiet("ovf_after", 2);

    $display("[TB] start while busy");
    applyStimulus(8'h05, 8'h03, 1'b0);
    checkOutput("midstart", 3);
    compare("midstart_sum_const", 32'(sum), 32'h08);
    checkQuiet("midstart_after", W + 2);

    $display("[TB] back-to-back");
    applyStimulus(8'h05, 8'h03, 1'b0);
    checkOutput("b2b_first", 0);
    applyStimulus(8'h10, 8'h20, 1'b0);
    checkOutput("b2b_second", 0);
    compare("b2b_sum_const", 32'(sum), 32'h30);
    checkQuiet("b2b_after", 2);

    $display("[TB] reset mid-operation");
    applyStimulus(8'h5A, 8'hC3, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compare("rst_mid_busy", 32'(busy), 32'd0);
    compare("rst_mid_done", 32'(done), 32'd0);
    compare("rst_mid_sum", 32'(sum), 32'd0);
    compare("rst_mid_cout", 32'(cout), 32'd0);
`ifdef SUM_SERIAL_OVF_EN
    compare("rst_mid_ovf", 32'(ovf), 32'd0);
`endif
    heldSum  = '0;
    heldCout = 1'b0;
    heldOvf  = 1'b0;
    checkQuiet("rst_mid_after", W + 3);

    $display("[TB] randomized operands");
    b2b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
      checkOutput($sformatf("rand%0d", i), 0);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) checkQuiet($sformatf("rand%0d_after", i), 1);
    end
    if (b2b) checkQuiet("rand_final", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_serial.md
Name: sum_serial

Overview:
- Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell (x, y, z -> s, c).
- Upstream side: loads operands and a carry-in, then feeds the cell one bit per clock, LSB first, with the registered carry fed back into z.
- Downstream side: consumes the cell's s/c outputs and assembles the final sum and carry-out.
- Used by the CPU datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request an addition; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  final carry-out, held with sum
- ovf  output  1  signed overflow (only with SUM_SERIAL_OVF_EN)

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high on rst.
- Reset: on a clk edge with rst=1, state=IDLE and every output is 0 (busy, done, sum, cout, ovf). Internal shift registers, carry flop and bit counter are also cleared. rst overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load shA=a, shB=b, carry=cin, cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Cell inputs are x=shA[0], y=shB[0], z=carry.
  - Shift shA and shB right by one.
  - Shift s into shS from the MSB end.
  - carry <= c.
  - cnt <= cnt+1.
  - After the edge that processes bit WIDTH-1 (cnt==WIDTH-1): go to DONE, sum <= final shS, cout <= c.
- DONE:
  - Lasts exactly one cycle with done=1.
  - If start=1 in this cycle, the new operands are accepted exactly as in IDLE and the next state is RUN (back-to-back operation). Otherwise the next state is IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+WIDTH. That is WIDTH+1 edges from start to the done cycle, and the throughput is one result per WIDTH+1 cycles.
- busy is 1 exactly in RUN, so it is high for WIDTH cycles per operation.
- start is ignored while busy. Operand changes during RUN have no effect.
- sum/cout update only on the RUN->DONE transition and hold through IDLE and any following RUN until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Operands are unsigned for cout and two's-complement for ovf.
- Counter width: $clog2(WIDTH). There is no wrap during RUN, because the FSM leaves RUN at cnt==WIDTH-1.
- Reset during RUN aborts the operation; no done pulse is produced.

Optional Feature:
- Macro: SUM_SERIAL_OVF_EN.
- Defined:
  - ovf port exists.
  - A flop captures the carry into the MSB (the carry register value when processing bit WIDTH-1).
  - ovf <= carry_into_msb XOR cout, updated together with sum/cout and reset to 0.
- Undefined: ovf port and the extra flop are absent; everything else is identical.

Decomposition:
- Package sum_serial_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default width constant SUM_WIDTH_DEF=8.
- Sub-module sum_bit: purely combinational one-bit full adder, ports x, y, z, s, c, with s=x^y^z and c=majority(x,y,z).
- sum_serial instantiates exactly one sum_bit.
- The FSM, shift registers, carry flop and counter stay in the top module.

Test Plan:
- Basic add (WIDTH=8): a=8'h0F, b=8'h01, cin=0, pulse start -> busy for 8 cycles, done at cycle 9 after start, sum=8'h10, cout=0.
- Carry chain and carry-in: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. With the macro, ovf=0.
- Signed overflow (macro defined): a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- Start while busy: start a=8'h05, b=8'h03; pulse start again with a=8'hAA mid-RUN -> ignored, sum=8'h08, single done pulse.
- Back-to-back: hold start=1 with a=8'h10, b=8'h20 during the done cycle of a prior add -> the next done comes exactly WIDTH+1 cycles later with sum=8'h30, and the previous sum is held until then.
- Reset mid-operation: assert rst for 1 cycle at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows.
